// File: rtl/barrel_unshifter.sv
// Pipelined right-rotator: out[j] = in[(j + select) mod SIZE], one register stage per select bit,
// valid/ready flow control with a global stall. Define UNSHIFT_STATS_EN to add the beat_count port.
module barrel_unshifter #(
    parameter int SIZE      = 64,
    parameter int DATAWIDTH = 8,
    localparam int STAGES   = $clog2(SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATAWIDTH*SIZE-1:0]   inarray,
    input  logic [STAGES-1:0]           select,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATAWIDTH*SIZE-1:0]   outarray
`ifdef UNSHIFT_STATS_EN
    ,
    output logic [15:0]                 beat_count
`endif
);

    localparam int W = DATAWIDTH * SIZE;

    logic              adv_s;
    logic [STAGES-1:0] v_r;

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;

    // Valid bits march with the data; the whole pipeline freezes when the output is blocked
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_r <= '0;
        end else if (adv_s) begin
            v_r <= (v_r << 1'b1) | STAGES'(in_valid);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SH = (1 << k) * DATAWIDTH;

        // Stage k only consumes select bit k, so it carries bits k..STAGES-1 (bit k at position 0)
        logic [STAGES-1-k:0] sel_s;
        logic [W-1:0]        prev_s;
        logic [W-1:0]        rot_s;
        logic [W-1:0]        q_r;

        if (k == 0) begin : g_head
            assign sel_s  = select;
            assign prev_s = inarray;
        end else begin : g_body
            logic [STAGES-1-k:0] sel_r;

            // Select copy travels alongside its beat so each stage sees the beat's own amount
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sel_r <= '0;
                end else if (adv_s) begin
                    sel_r <= g_stage[k-1].sel_s[STAGES-k:1];
                end
            end

            assign sel_s  = sel_r;
            assign prev_s = g_stage[k-1].q_r;
        end

        // Element j takes element j + 2^k: the packed vector moves toward the LSB with wrap
        assign rot_s = {prev_s[SH-1:0], prev_s[W-1:SH]};

        // Data loads on every advance regardless of valid; valid bits qualify it downstream
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q_r <= '0;
            end else if (adv_s) begin
                q_r <= sel_s[0] ? rot_s : prev_s;
            end
        end
    end

    assign outarray  = g_stage[STAGES-1].q_r;
    assign out_valid = v_r[STAGES-1];

`ifdef UNSHIFT_STATS_EN
    // Completed output transfers, wrapping at 2^16
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_count <= 16'd0;
        end else if (out_valid & out_ready) begin
            beat_count <= beat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_barrel_unshifter.sv
// Self-checking bench for barrel_unshifter (SIZE=8, DATAWIDTH=8) with a scoreboard and a
// behavioural rotate model; checks beat_count too when UNSHIFT_STATS_EN is defined.
module tb_barrel_unshifter;

    localparam int SIZE   = 8;
    localparam int DW     = 8;
    localparam int STAGES = 3;
    localparam int W      = SIZE * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      inarray;
    logic [STAGES-1:0] select;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      outarray;
`ifdef UNSHIFT_STATS_EN
    logic [15:0]       beat_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    barrel_unshifter #(
        .SIZE      (SIZE),
        .DATAWIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inarray   (inarray),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outarray  (outarray)
`ifdef UNSHIFT_STATS_EN
        ,
        .beat_count(beat_count)
`endif
    );

    // out[j] = in[(j + s) mod SIZE]
    function automatic logic [W-1:0] rot_right(input logic [W-1:0] a, input int s);
        logic [W-1:0] r;
        for (int j = 0; j < SIZE; j++) r[j*DW +: DW] = a[((j + s) % SIZE)*DW +: DW];
        return r;
    endfunction

    // The companion left-rotating shifter: out[j] = in[(j - s) mod SIZE]
    function automatic logic [W-1:0] rot_left(input logic [W-1:0] a, input int s);
        logic [W-1:0] r;
        for (int j = 0; j < SIZE; j++) r[j*DW +: DW] = a[((j - s + SIZE) % SIZE)*DW +: DW];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        select    = '0;
        inarray   = '0;
        rst       = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        int seen;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || outarray !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle out_valid=%b outarray=%h in_ready=%b exp 0/0/1", out_valid, outarray, in_ready);
        end
        repeat (2) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inarray = {$urandom, $urandom} | 64'd1;
            select  = STAGES'($urandom_range(0, SIZE-1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload out_valid=%b exp 1", out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || outarray !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midrun out_valid=%b outarray=%h in_ready=%b exp 0/0/1", out_valid, outarray, in_ready);
        end
        repeat (2) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_flush beats_after_reset=%0d exp 0", seen);
        end
    endtask

    task automatic test_basic;
        int           sels [3] = '{3, 0, 7};
        logic [W-1:0] exps [3] = '{64'h0201_0007_0605_0403, 64'h0706_0504_0302_0100, 64'h0605_0403_0201_0007};
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            inarray   = 64'h0706_0504_0302_0100;
            select    = STAGES'(sels[c]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int t = 1; t <= STAGES + 1; t++) begin
                if (t > 1) tick();
                checks++;
                if (t == STAGES) begin
                    if (out_valid !== 1'b1 || outarray !== exps[c]) begin
                        errors++;
                        $display("FAIL basic_out sel=%0d valid=%b got=%h exp=%h", sels[c], out_valid, outarray, exps[c]);
                    end
                end else if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_timing sel=%0d cycle=%0d out_valid=%b exp 0", sels[c], t, out_valid);
                end
            end
        end
    endtask

    // mode 0: always ready, select = i mod SIZE; mode 1: ready 1,0,0,1; mode 2: random ready
    task automatic test_stream(input string name, input int n, input int mode, input bit round_trip);
        logic [W-1:0]      in_q [$];
        logic [STAGES-1:0] sel_q[$];
        logic [W-1:0]      exp_q[$];
        logic [W-1:0]      a, prev_out, e;
        int                s, got, cyc, first_out, last_out;
        bit                in_fire, out_fire, stalled_prev;
        apply_reset();
        for (int i = 0; i < n; i++) begin
            a = {$urandom, $urandom};
            s = (mode == 0) ? (i % SIZE) : int'($urandom_range(0, SIZE-1));
            sel_q.push_back(STAGES'(s));
            if (round_trip) begin
                in_q.push_back(rot_left(a, s));
                exp_q.push_back(a);
            end else begin
                in_q.push_back(a);
                exp_q.push_back(rot_right(a, s));
            end
        end
        got = 0; cyc = 0; first_out = -1; last_out = -1;
        stalled_prev = 1'b0; prev_out = '0;
        while (got < n && cyc < 4*n + 50) begin
            in_valid = (in_q.size() > 0);
            inarray  = (in_q.size() > 0) ? in_q[0] : '0;
            select   = (sel_q.size() > 0) ? sel_q[0] : '0;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL %s_in_ready cyc=%0d got=%b out_valid=%b out_ready=%b", name, cyc, in_ready, out_valid, out_ready);
            end
            if (stalled_prev) begin
                checks++;
                if (out_valid !== 1'b1 || outarray !== prev_out) begin
                    errors++;
                    $display("FAIL %s_stall_hold cyc=%0d valid=%b got=%h exp=%h", name, cyc, out_valid, outarray, prev_out);
                end
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if (outarray !== e) begin
                    errors++;
                    $display("FAIL %s_data beat=%0d got=%h exp=%h", name, got, outarray, e);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            stalled_prev = out_valid && !out_ready;
            prev_out     = outarray;
            tick();
            if (in_fire) begin
                void'(in_q.pop_front());
                void'(sel_q.pop_front());
            end
            if (out_fire) got++;
            cyc++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_count delivered=%0d exp=%0d", name, got, n);
        end
        if (mode == 0) begin
            checks++;
            if (first_out != STAGES || last_out - first_out != n - 1) begin
                errors++;
                $display("FAIL %s_rate first=%0d last=%0d exp first=%0d span=%0d", name, first_out, last_out, STAGES, n - 1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        repeat (STAGES + 2) begin
            tick();
            if (out_valid) got++;
        end
        checks++;
        if (got != 0) begin
            errors++;
            $display("FAIL %s_extra extra_beats=%0d exp 0", name, got);
        end
`ifdef UNSHIFT_STATS_EN
        checks++;
        if (beat_count !== 16'(n)) begin
            errors++;
            $display("FAIL %s_beat_count got=%0d exp=%0d", name, beat_count, n);
        end
`endif
    endtask

    task automatic test_back_to_back;
        test_stream("back_to_back", 8, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        test_stream("backpressure", 6, 1, 1'b0);
    endtask

    task automatic test_round_trip;
        test_stream("round_trip", 1000, 2, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inarray   = '0;
        select    = '0;
        #2;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_round_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_unshifter.md
Name: barrel_unshifter

Overview:
- Pipelined inverse rotator: rotates a packed array of SIZE elements right by `select` element positions, so that `out[j] = in[(j + select) mod SIZE]`.
- Undoes our left-rotating pipelined barrel shifter. Feeding that shifter's output here with the same select value recovers the original array.
- One register stage per select bit, with valid/ready flow control so it can sit between stream producers and consumers.

Parameters:
- SIZE, 64: number of elements. Must be a power of two and at least 2.
- DATAWIDTH, 8: bits per element.
- STAGES, $clog2(SIZE): derived, not overridden. Equals the number of pipeline stages and the select width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- inarray  input  DATAWIDTH*SIZE  packed input; element i occupies bits [(i+1)*DATAWIDTH-1 : i*DATAWIDTH].
- select  input  STAGES  right-rotate amount, 0..SIZE-1.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the output beat.
- outarray  output  DATAWIDTH*SIZE  packed rotated result, same element packing as inarray.

Behaviour:
- Reset (rst low, asynchronous):
  - all stage data registers, all stage valid bits and all per-stage select copies clear to 0;
  - out_valid = 0 and outarray = 0;
  - in_ready = 1 immediately, since the output stage is empty.
- Advance enable: adv = ~out_valid | out_ready.
  - The whole pipeline moves together when adv = 1 and freezes entirely when adv = 0 (global stall, no bubble collapsing).
  - in_ready = adv, driven combinationally.
- Stage operation:
  - Stage k (k = 0..STAGES-1) computes `d_k[j] = sel_k[k] ? q_{k-1}[(j + 2^k) mod SIZE] : q_{k-1}[j]`.
  - q_{-1} = inarray and sel_0 = select.
  - On adv = 1: q_k <= d_k, sel_{k+1} <= sel_k, v_k <= v_{k-1}, with v_{-1} = in_valid.
  - Data and select registers load on adv regardless of valid; only valid bits qualify the data.
- Outputs: outarray = q_{STAGES-1} and out_valid = v_{STAGES-1}.
- Latency: STAGES cycles from the accepting edge to out_valid, with no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Transfer rules:
  - an input transfer happens on an edge with in_valid & in_ready;
  - an output transfer happens on an edge with out_valid & out_ready;
  - simultaneous accept and deliver in the same cycle is legal and required to work at full rate.
- Stall: while out_valid = 1 and out_ready = 0, outarray and out_valid hold stable and in_ready = 0. Inputs presented during the stall are not captured.
- Boundary cases:
  - select = 0 passes data unchanged;
  - select = SIZE-1 is equivalent to a rotate left by 1;
  - wrap-around indices are taken mod SIZE.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- Ordering: beats emerge in acceptance order; none are dropped or duplicated.

Optional Feature:
- Macro: UNSHIFT_STATS_EN.
- Defined:
  - adds output port `beat_count`, output, 16 bits;
  - counts completed output transfers (out_valid & out_ready);
  - wraps modulo 2^16;
  - clears to 0 on reset.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Reset/idle: assert rst low mid-run with 2 beats in flight -> out_valid = 0, outarray = 0, in_ready = 1 during reset; no beats emerge after release.
- Basic rotate (SIZE=8, DATAWIDTH=8): inarray elements 0..7 = 0x00..0x07, select=3, out_ready=1 -> after 3 cycles out_valid=1 and elements = 03,04,05,06,07,00,01,02.
- Boundaries (SIZE=8): select=0 -> elements 00..07 unchanged; select=7 -> elements 07,00,01,02,03,04,05,06.
- Back-to-back: 8 consecutive beats with select=0..7, out_ready=1 -> 8 consecutive out_valid cycles with results matching the reference model, in order.
- Backpressure: stream 6 beats with out_ready toggling 1,0,0,1 repeatedly -> outarray stable whenever stalled, in_ready=0 exactly while out_valid=1 and out_ready=0, all 6 beats correct and none lost.
- Round trip: drive random arrays through the barrel shifter, then this block with the same select -> output equals the original array for 1000 random vectors. With UNSHIFT_STATS_EN defined, beat_count = 1000 at the end.
